bus_interface: RTL and testbench
================================

BUS_INTERFACE -- requirements
Module: bus_interface

Interface
REQ-001 Clock  input  1  system clock; all state updates on the rising edge.
REQ-002 nReset  input  1  reset, asynchronous, active-low.
REQ-003 ReqValid  input  1  control requests a bus cycle; held high until ReqReady.
REQ-004 ReqWrite  input  1  request type: 1 = write, 0 = read.
REQ-005 ReqAddr  input  16  word address of the request.
REQ-006 ReqWData  input  16  write data.
REQ-007 WaitStates  input  2  extra strobe cycles, 0..3.
REQ-008 ReqReady  output  1  one-cycle completion pulse.
REQ-009 RData  output  16  read data; valid with ReqReady; held until the next read completes.
REQ-010 BusErr  output  1  timeout flag; valid with ReqReady.
REQ-011 Busy  output  1  high in every state except IDLE.
REQ-012 BusOut  output  16  multiplexed address/data driven onto the system bus.
REQ-013 BusOe  output  1  bus driver enable, active-high.
REQ-014 BusIn  input  16  system bus read value.
REQ-015 ALE  output  1  address latch enable, active-high.
REQ-016 nME  output  1  memory enable, active-low.
REQ-017 nOE  output  1  read strobe, active-low.
REQ-018 nWE  output  1  write strobe, active-low.
REQ-019 nWait  input  1  memory wait request, active-low.

Function
REQ-020 FSM states SHALL be IDLE, ADDR, STROBE, RECOVER; all outputs SHALL be registered or decoded only from state/latched registers.
REQ-021 IDLE: when ReqValid=1 at a rising edge, the block SHALL latch ReqAddr, ReqWData, ReqWrite and WaitStates, then enter ADDR.
REQ-022 Request inputs SHALL be ignored outside IDLE.
REQ-023 ADDR (1 cycle) SHALL drive:
  - ALE=1, nME=0, BusOe=1, BusOut=latched address;
  - then enter STROBE, with the wait counter loaded from latched WaitStates.
REQ-024 STROBE, read: nME=0, nOE=0, BusOe=0.
REQ-025 STROBE, write: nME=0, nWE=0, BusOe=1, BusOut=latched write data.
REQ-026 STROBE counter handling:
  - counter decrements each cycle while nonzero;
  - the final STROBE cycle is the first cycle with counter=0 and nWait=1;
  - after it, the block SHALL enter RECOVER.
REQ-027 On the edge ending the final STROBE cycle of a read, RData SHALL capture BusIn.
REQ-028 nWait SHALL be ignored while the counter is nonzero.
REQ-029 While counter=0 and nWait=0, a timeout counter SHALL increment.
  - At 16 consecutive such cycles the block SHALL abort to RECOVER with BusErr=1.
  - RData SHALL be left unchanged on abort.
REQ-030 RECOVER (1 cycle) SHALL drive:
  - all strobes inactive, BusOe=0, ReqReady=1;
  - then return to IDLE.
REQ-031 BusErr SHALL be 0 on normal completion and SHALL be low whenever ReqReady is low.
REQ-032 Read latency with WaitStates=0 and nWait=1: acceptance edge T, then:
  - ADDR in cycle T+1;
  - STROBE in cycle T+2;
  - ReqReady in cycle T+3.
  Each wait state or nWait-low cycle SHALL add exactly one cycle.
REQ-033 Minimum request spacing SHALL be 4 cycles. A request that ReqValid still shows in the RECOVER cycle SHALL be accepted at the edge leaving IDLE on the next cycle.
REQ-034 ALE, nOE and nWE SHALL never be active in the same cycle; nOE and nWE SHALL never both be low.

Reset
REQ-035 nReset low SHALL asynchronously force:
  - state IDLE; ALE=0, nME=1, nOE=1, nWE=1;
  - BusOe=0, BusOut=0, ReqReady=0, BusErr=0, Busy=0, RData=0;
  - all counters and latched request registers = 0.
REQ-036 Reset mid-cycle SHALL abandon the transfer with no ReqReady pulse.

Structure
REQ-037 A shared CPU package SHALL hold:
  - the bus state enum;
  - bus width (16);
  - timeout limit (16).
REQ-038 The block SHALL be a single module; no sub-module is required.

Verification
REQ-039 Read, WaitStates=0, BusIn=16'hA5C3, addr 16'h0100:
  - ALE in T+1 with BusOut=16'h0100;
  - nOE low in T+2;
  - ReqReady in T+3 with RData=16'hA5C3.
REQ-040 Write 16'h1234 to 16'h0200, WaitStates=2:
  - nWE low for exactly 3 cycles with BusOut=16'h1234, BusOe=1;
  - ReqReady 5 cycles after acceptance.
REQ-041 Read, WaitStates=1, nWait held low 3 cycles after counter expiry:
  - nOE low for 5 cycles;
  - ReqReady with BusErr=0.
REQ-042 nWait stuck low:
  - ReqReady with BusErr=1 after 16 timeout cycles;
  - RData retains the previous read value.
REQ-043 Back-to-back reads with ReqValid held high: second ALE exactly 4 cycles after the first.
REQ-044 nReset asserted during STROBE:
  - nOE=1, BusOe=0, Busy=0 immediately;
  - no ReqReady pulse;
  - next request completes normally.

Source files
------------

// File: rtl/bus_interface_pkg.sv
// Shared CPU bus definitions: bus state encoding, bus width and strobe timeout.
package bus_interface_pkg;

    localparam int BUS_WIDTH     = 16;
    localparam int TIMEOUT_LIMIT = 16;
    localparam int TIMEOUT_W     = $clog2(TIMEOUT_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        STROBE  = 2'd2,
        RECOVER = 2'd3
    } bus_state_t;

endpackage

// File: rtl/bus_interface.sv
// Multiplexed address/data bus master: turns a single request handshake into an
// ALE / strobe / recover cycle with programmable wait states and an nWait timeout.
module bus_interface
    import bus_interface_pkg::*;
(
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 ReqValid,
    input  logic                 ReqWrite,
    input  logic [BUS_WIDTH-1:0] ReqAddr,
    input  logic [BUS_WIDTH-1:0] ReqWData,
    input  logic [1:0]           WaitStates,
    output logic                 ReqReady,
    output logic [BUS_WIDTH-1:0] RData,
    output logic                 BusErr,
    output logic                 Busy,
    output logic [BUS_WIDTH-1:0] BusOut,
    output logic                 BusOe,
    input  logic [BUS_WIDTH-1:0] BusIn,
    output logic                 ALE,
    output logic                 nME,
    output logic                 nOE,
    output logic                 nWE,
    input  logic                 nWait
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_LIMIT - 1);

    bus_state_t           state;
    bus_state_t           next_state;
    logic [BUS_WIDTH-1:0] addr_q;
    logic [BUS_WIDTH-1:0] wdata_q;
    logic                 write_q;
    logic [1:0]           ws_q;
    logic [1:0]           wait_cnt;
    logic [TIMEOUT_W-1:0] timeout_cnt;
    logic [BUS_WIDTH-1:0] rdata_q;
    logic                 err_q;
    logic                 wait_done;
    logic                 strobe_end;
    logic                 timed_out;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // nWait only matters once the programmed wait states have been used up.
    always_comb begin
        wait_done  = (wait_cnt == 2'd0);
        strobe_end = wait_done && nWait;
        timed_out  = wait_done && !nWait && (timeout_cnt == TIMEOUT_LAST);
        next_state = state;
        case (state)
            IDLE:    if (ReqValid) next_state = ADDR;
            ADDR:    next_state = STROBE;
            STROBE:  if (strobe_end || timed_out) next_state = RECOVER;
            RECOVER: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // err_q is rewritten every cycle so it can only be high in the RECOVER after an abort.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            ws_q        <= 2'd0;
            wait_cnt    <= 2'd0;
            timeout_cnt <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        addr_q  <= ReqAddr;
                        wdata_q <= ReqWData;
                        write_q <= ReqWrite;
                        ws_q    <= WaitStates;
                    end
                end
                ADDR: begin
                    wait_cnt    <= ws_q;
                    timeout_cnt <= '0;
                end
                STROBE: begin
                    if (!wait_done) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end else if (nWait) begin
                        if (!write_q) rdata_q <= BusIn;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus pins are pure decodes of the state and the latched request.
    always_comb begin
        ALE    = 1'b0;
        nME    = 1'b1;
        nOE    = 1'b1;
        nWE    = 1'b1;
        BusOe  = 1'b0;
        BusOut = '0;
        case (state)
            ADDR: begin
                ALE    = 1'b1;
                nME    = 1'b0;
                BusOe  = 1'b1;
                BusOut = addr_q;
            end
            STROBE: begin
                nME = 1'b0;
                if (write_q) begin
                    nWE    = 1'b0;
                    BusOe  = 1'b1;
                    BusOut = wdata_q;
                end else begin
                    nOE = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign ReqReady = (state == RECOVER);
    assign Busy     = (state != IDLE);
    assign BusErr   = err_q;
    assign RData    = rdata_q;

endmodule

// File: tb/tb_bus_interface.sv
// Scenario bench for bus_interface: expected completions are queued when a request
// is issued and checked against RData/BusErr when ReqReady pulses.
module tb_bus_interface;

    logic        Clock;
    logic        nReset;
    logic        ReqValid;
    logic        ReqWrite;
    logic [15:0] ReqAddr;
    logic [15:0] ReqWData;
    logic [1:0]  WaitStates;
    logic        ReqReady;
    logic [15:0] RData;
    logic        BusErr;
    logic        Busy;
    logic [15:0] BusOut;
    logic        BusOe;
    logic [15:0] BusIn;
    logic        ALE;
    logic        nME;
    logic        nOE;
    logic        nWE;
    logic        nWait;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_rdata;
    int          vectors;
    int          miscompares;

    bus_interface dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .ReqValid   (ReqValid),
        .ReqWrite   (ReqWrite),
        .ReqAddr    (ReqAddr),
        .ReqWData   (ReqWData),
        .WaitStates (WaitStates),
        .ReqReady   (ReqReady),
        .RData      (RData),
        .BusErr     (BusErr),
        .Busy       (Busy),
        .BusOut     (BusOut),
        .BusOe      (BusOe),
        .BusIn      (BusIn),
        .ALE        (ALE),
        .nME        (nME),
        .nOE        (nOE),
        .nWE        (nWE),
        .nWait      (nWait)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Runs one transfer from the acceptance edge until ReqReady, driving nWait low
    // in cycles lo_from..lo_to (cycle 1 = ADDR) and tallying strobe activity.
    task automatic run_until_ready(input int limit, input int lo_from, input int lo_to,
                                   input logic [15:0] wdata, output int ready_k,
                                   output int oe_low, output int we_low, output int bad_cycles);
        ready_k    = 0;
        oe_low     = 0;
        we_low     = 0;
        bad_cycles = 0;
        tick();
        for (int k = 1; k <= limit; k++) begin
            nWait = (k >= lo_from && k <= lo_to) ? 1'b0 : 1'b1;
            if (!nOE) oe_low++;
            if (!nWE) we_low++;
            if ((ALE && (!nOE || !nWE)) || (!nOE && !nWE)) bad_cycles++;
            if (!nWE && (BusOut !== wdata || BusOe !== 1'b1)) bad_cycles++;
            if (!ReqReady && BusErr) bad_cycles++;
            if (ReqReady) begin
                ready_k  = k;
                ReqValid = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        tick();
        vectors++;
        if ({ALE, nME, nOE, nWE, BusOe, ReqReady, BusErr, Busy} !== 8'b0111_0000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 01110000", {ALE, nME, nOE, nWE, BusOe, ReqReady, BusErr, Busy});
        end
        vectors++;
        if (BusOut !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_busout: got %h, expected 0000", BusOut);
        end
        vectors++;
        if (RData !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_rdata: got %h, expected 0000", RData);
        end
        ReqValid = 1'b1;
        tick();
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_holds_idle: Busy=%b, expected 0", Busy);
        end
        ReqValid = 1'b0;
        nReset   = 1'b1;
        tick();
        tick();
        vectors++;
        if (Busy !== 1'b0 || ReqReady !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: Busy=%b ReqReady=%b, expected 0 0", Busy, ReqReady);
        end
    endtask

    task automatic test_read();
        exp_t e;
        BusIn       = 16'hA5C3;
        model_rdata = 16'hA5C3;
        sb.push_back('{16'hA5C3, 1'b0});
        ReqValid   = 1'b1;
        ReqWrite   = 1'b0;
        ReqAddr    = 16'h0100;
        WaitStates = 2'd0;
        nWait      = 1'b1;
        tick();
        vectors++;
        if (ALE !== 1'b1 || BusOut !== 16'h0100 || BusOe !== 1'b1 || nME !== 1'b0 || nOE !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL read_addr: ALE=%b BusOut=%h BusOe=%b nME=%b nOE=%b, expected 1 0100 1 0 1", ALE, BusOut, BusOe, nME, nOE);
        end
        ReqAddr  = 16'hFFFF;
        ReqWrite = 1'b1;
        tick();
        vectors++;
        if (nOE !== 1'b0 || nWE !== 1'b1 || BusOe !== 1'b0 || ALE !== 1'b0 || nME !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL read_strobe: nOE=%b nWE=%b BusOe=%b ALE=%b nME=%b, expected 0 1 0 0 0", nOE, nWE, BusOe, ALE, nME);
        end
        tick();
        vectors++;
        if (ReqReady !== 1'b1 || nOE !== 1'b1 || BusOe !== 1'b0 || nME !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL read_ready: ReqReady=%b nOE=%b BusOe=%b nME=%b, expected 1 1 0 1", ReqReady, nOE, BusOe, nME);
        end
        e = sb.pop_front();
        vectors++;
        if (RData !== e.rdata || BusErr !== e.err) begin
            miscompares++;
            $display("[TB] FAIL read_result: RData=%h BusErr=%b, expected %h %b", RData, BusErr, e.rdata, e.err);
        end
        ReqValid = 1'b0;
        ReqWrite = 1'b0;
        tick();
        vectors++;
        if (Busy !== 1'b0 || ReqReady !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL read_idle: Busy=%b ReqReady=%b, expected 0 0", Busy, ReqReady);
        end
    endtask

    task automatic test_write();
        exp_t e;
        int   ready_k, oe_low, we_low, bad;
        sb.push_back('{model_rdata, 1'b0});
        ReqValid   = 1'b1;
        ReqWrite   = 1'b1;
        ReqAddr    = 16'h0200;
        ReqWData   = 16'h1234;
        WaitStates = 2'd2;
        run_until_ready(20, 0, -1, 16'h1234, ready_k, oe_low, we_low, bad);
        vectors++;
        if (ready_k != 5) begin
            miscompares++;
            $display("[TB] FAIL write_latency: ReqReady in cycle %0d, expected 5", ready_k);
        end
        vectors++;
        if (we_low != 3 || oe_low != 0) begin
            miscompares++;
            $display("[TB] FAIL write_strobe: nWE low %0d nOE low %0d cycles, expected 3 0", we_low, oe_low);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL write_bus: %0d bad cycles, expected 0", bad);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (RData !== e.rdata || BusErr !== e.err) begin
                miscompares++;
                $display("[TB] FAIL write_result: RData=%h BusErr=%b, expected %h %b", RData, BusErr, e.rdata, e.err);
            end
        end
        ReqWrite = 1'b0;
        tick();
    endtask

    task automatic test_wait();
        exp_t e;
        int   ready_k, oe_low, we_low, bad;
        BusIn       = 16'h5A3C;
        model_rdata = 16'h5A3C;
        sb.push_back('{16'h5A3C, 1'b0});
        ReqValid   = 1'b1;
        ReqWrite   = 1'b0;
        ReqAddr    = 16'h0110;
        WaitStates = 2'd1;
        run_until_ready(30, 2, 5, 16'h0000, ready_k, oe_low, we_low, bad);
        nWait = 1'b1;
        vectors++;
        if (oe_low != 5 || we_low != 0) begin
            miscompares++;
            $display("[TB] FAIL wait_strobe: nOE low %0d nWE low %0d cycles, expected 5 0", oe_low, we_low);
        end
        vectors++;
        if (ready_k != 7 || bad != 0) begin
            miscompares++;
            $display("[TB] FAIL wait_latency: ReqReady cycle %0d bad %0d, expected 7 0", ready_k, bad);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (RData !== e.rdata || BusErr !== e.err) begin
                miscompares++;
                $display("[TB] FAIL wait_result: RData=%h BusErr=%b, expected %h %b", RData, BusErr, e.rdata, e.err);
            end
        end
        tick();
    endtask

    task automatic test_timeout();
        exp_t e;
        int   ready_k, oe_low, we_low, bad;
        BusIn = 16'hDEAD;
        sb.push_back('{model_rdata, 1'b1});
        ReqValid   = 1'b1;
        ReqWrite   = 1'b0;
        ReqAddr    = 16'h0120;
        WaitStates = 2'd0;
        run_until_ready(40, 1, 1000, 16'h0000, ready_k, oe_low, we_low, bad);
        vectors++;
        if (ready_k != 18 || oe_low != 16) begin
            miscompares++;
            $display("[TB] FAIL timeout_latency: ReqReady cycle %0d nOE low %0d, expected 18 16", ready_k, oe_low);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL timeout_strobes: %0d bad cycles, expected 0", bad);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (RData !== e.rdata || BusErr !== e.err) begin
                miscompares++;
                $display("[TB] FAIL timeout_result: RData=%h BusErr=%b, expected %h %b", RData, BusErr, e.rdata, e.err);
            end
        end
        nWait = 1'b1;
        tick();
        vectors++;
        if (BusErr !== 1'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_clear: BusErr=%b Busy=%b, expected 0 0", BusErr, Busy);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          first_ale, second_ale, ready_seen;
        logic [15:0] second_addr;
        first_ale   = 0;
        second_ale  = 0;
        ready_seen  = 0;
        second_addr = 16'h0000;
        BusIn       = 16'h1111;
        sb.push_back('{16'h1111, 1'b0});
        ReqValid   = 1'b1;
        ReqWrite   = 1'b0;
        ReqAddr    = 16'h0300;
        WaitStates = 2'd0;
        nWait      = 1'b1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            if (ALE) begin
                if (first_ale == 0) begin
                    first_ale = k;
                end else if (second_ale == 0) begin
                    second_ale  = k;
                    second_addr = BusOut;
                end
            end
            if (ReqReady) begin
                ready_seen++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    vectors++;
                    if (RData !== e.rdata || BusErr !== e.err) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_result%0d: RData=%h BusErr=%b, expected %h %b", ready_seen, RData, BusErr, e.rdata, e.err);
                    end
                end
                if (ready_seen == 1) begin
                    ReqAddr = 16'h0304;
                    BusIn   = 16'h2222;
                    sb.push_back('{16'h2222, 1'b0});
                end else begin
                    ReqValid = 1'b0;
                    break;
                end
            end
            tick();
        end
        model_rdata = 16'h2222;
        vectors++;
        if (ready_seen != 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_count: %0d completions, expected 2", ready_seen);
        end
        vectors++;
        if (first_ale == 0 || second_ale - first_ale != 4) begin
            miscompares++;
            $display("[TB] FAIL b2b_spacing: ALE cycles %0d and %0d, expected spacing 4", first_ale, second_ale);
        end
        vectors++;
        if (second_addr !== 16'h0304) begin
            miscompares++;
            $display("[TB] FAIL b2b_addr: second address %h, expected 0304", second_addr);
        end
        ReqValid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   pulses, ready_k, oe_low, we_low, bad;
        pulses     = 0;
        BusIn      = 16'hBEEF;
        ReqValid   = 1'b1;
        ReqWrite   = 1'b0;
        ReqAddr    = 16'h0400;
        WaitStates = 2'd3;
        nWait      = 1'b1;
        tick();
        ReqValid = 1'b0;
        tick();
        vectors++;
        if (nOE !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_strobe: nOE=%b, expected 0", nOE);
        end
        #2;
        nReset = 1'b0;
        #1;
        vectors++;
        if ({nOE, BusOe, Busy, nME} !== 4'b1001) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_outputs: nOE/BusOe/Busy/nME=%b, expected 1001", {nOE, BusOe, Busy, nME});
        end
        sb.delete();
        model_rdata = 16'h0000;
        vectors++;
        if (RData !== model_rdata) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_rdata: RData=%h, expected %h", RData, model_rdata);
        end
        @(posedge Clock);
        #1;
        nReset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (ReqReady || Busy) pulses++;
            tick();
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_no_ready: %0d busy/ready cycles, expected 0", pulses);
        end
        BusIn       = 16'h0BEE;
        model_rdata = 16'h0BEE;
        sb.push_back('{16'h0BEE, 1'b0});
        ReqValid   = 1'b1;
        ReqAddr    = 16'h0500;
        WaitStates = 2'd0;
        run_until_ready(10, 0, -1, 16'h0000, ready_k, oe_low, we_low, bad);
        vectors++;
        if (ready_k != 3 || oe_low != 1 || bad != 0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_next: ready cycle %0d nOE low %0d bad %0d, expected 3 1 0", ready_k, oe_low, bad);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (RData !== e.rdata || BusErr !== e.err) begin
                miscompares++;
                $display("[TB] FAIL rst_mid_result: RData=%h BusErr=%b, expected %h %b", RData, BusErr, e.rdata, e.err);
            end
        end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_rdata = 16'h0000;
        nReset      = 1'b1;
        ReqValid    = 1'b0;
        ReqWrite    = 1'b0;
        ReqAddr     = 16'h0000;
        ReqWData    = 16'h0000;
        WaitStates  = 2'd0;
        BusIn       = 16'h0000;
        nWait       = 1'b1;
        #2;
        nReset = 1'b0;

        test_reset();
        test_read();
        test_write();
        test_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
